// File: rtl/ctrl_pkg.sv
// Shared encodings for the branch/hazard control slice of the RISC-V pipeline.
package ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_STALL_LU = 2'd3;

    // Canonical NOP (addi x0, x0, 0) that a flushed IF/ID register represents.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between ID/EX and IF/ID.
module load_use_detect
    import ctrl_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    output logic       load_use
);

    logic w_rd_nonzero;
    logic w_rd_match;

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    assign w_rd_nonzero = (idex_rd != 5'd0);
    assign w_rd_match   = (idex_rd == ifid_rs1) || (idex_rd == ifid_rs2);
    assign load_use     = idex_memread && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch redirect / flush / load-use stall sequencer with saturating branch statistics.
//
//   state    | meaning
//   RUN      | normal fetch, evaluate EX branch and load-use hazard
//   REDIRECT | PC loads latched target, flush IF/ID and ID/EX
//   FLUSH    | remaining flush cycles after the redirect
//   STALL_LU | freeze PC and IF/ID, insert one bubble into ID/EX
module branch_hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        FLUSH_CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [XLEN-1:0]        r_tgt_q;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
    logic [CNT_W-1:0]       r_branch_cnt;
    logic [CNT_W-1:0]       r_taken_cnt;

    logic w_load_use;
    logic w_branch_ev;
    logic w_taken_ev;
    logic w_pc_write_raw;
    logic w_ifid_write_raw;

    load_use_detect u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .load_use     (w_load_use)
    );

    assign w_branch_ev = (r_state == ST_RUN) && ex_valid && ex_is_branch && !mem_stall;
    assign w_taken_ev  = w_branch_ev && ex_taken;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (ex_valid && ex_is_branch && ex_taken) begin
                    w_state_nxt = ST_REDIRECT;
                end else if (w_load_use) begin
                    w_state_nxt = ST_STALL_LU;
                end
            end
            ST_REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // mem_stall freezes every piece of state, including the statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_tgt_q     <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_stall) begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (r_state == ST_RUN && ex_valid && ex_is_branch && ex_taken) begin
                r_tgt_q <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_branch_ev && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_taken_ev && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_pc_write_raw   = 1'b1;
        w_ifid_write_raw = 1'b1;
        pc_sel           = 1'b0;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;
        case (r_state)
            ST_REDIRECT: begin
                pc_sel     = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ST_STALL_LU: begin
                w_pc_write_raw   = 1'b0;
                w_ifid_write_raw = 1'b0;
                idex_flush       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Flushes stay asserted under mem_stall: re-clearing a register is harmless.
    assign pc_write    = w_pc_write_raw && !mem_stall;
    assign ifid_write  = w_ifid_write_raw && !mem_stall;
    assign redirect_pc = r_tgt_q;
    assign branch_cnt  = r_branch_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: default instance plus a FLUSH_CYCLES=1, 4-bit counter instance.
module tb_branch_hazard_ctrl;

    logic        clk;
    logic        reset_n;
    logic        mem_stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [63:0] ex_target;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;

    logic        pc_write, pc_sel, ifid_write, ifid_flush, idex_flush;
    logic [63:0] redirect_pc;
    logic [31:0] branch_cnt, taken_cnt;

    logic        s_pc_write, s_pc_sel, s_ifid_write, s_ifid_flush, s_idex_flush;
    logic [63:0] s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .pc_write(pc_write), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(1), .CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .pc_write(s_pc_write), .pc_sel(s_pc_sel), .redirect_pc(s_redirect_pc),
        .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush} of the main instance.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {59'd0, pc_write, pc_sel, ifid_write, ifid_flush, idex_flush}, {59'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_taken     = 1'b0;
        idex_memread = 1'b0;
        idex_rd      = 5'd0;
        ifid_rs1     = 5'd0;
        ifid_rs2     = 5'd0;
    endtask

    task automatic set_taken(input logic [63:0] tgt);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b1;
        ex_target    = tgt;
    endtask

    //                     pcw sel ifw iff idf
    localparam logic [4:0] C_RUN   = 5'b1_0_1_0_0;
    localparam logic [4:0] C_REDIR = 5'b1_1_1_1_1;
    localparam logic [4:0] C_FLUSH = 5'b1_0_1_1_1;
    localparam logic [4:0] C_STALL = 5'b0_0_0_0_1;
    localparam logic [4:0] C_REDMS = 5'b0_1_0_1_1;

    initial begin
        reset_n   = 1'b0;
        mem_stall = 1'b0;
        ex_target = 64'd0;
        clear_ex();
        #12;
        chk_ctl("reset_ctl", C_RUN);
        chk("reset_redirect_pc", redirect_pc, 64'd0);
        chk("reset_branch_cnt", {32'd0, branch_cnt}, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1;
            cyc();
            chk_ctl("idle_ctl", C_RUN);
        end
        chk("idle_branch_cnt", {32'd0, branch_cnt}, 64'd0);
        chk("idle_taken_cnt", {32'd0, taken_cnt}, 64'd0);

        set_taken(64'h0000_0000_0000_1040);
        cyc();
        chk_ctl("t2_redirect_ctl", C_REDIR);
        chk("t2_redirect_pc", redirect_pc, 64'h1040);
        clear_ex();
        cyc();
        chk_ctl("t2_flush_ctl", C_FLUSH);
        cyc();
        chk_ctl("t2_run_ctl", C_RUN);
        chk("t2_branch_cnt", {32'd0, branch_cnt}, 64'd1);
        chk("t2_taken_cnt", {32'd0, taken_cnt}, 64'd1);

        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b0;
        ex_target    = 64'h2222;
        cyc();
        clear_ex();
        chk_ctl("t3_nt_ctl", C_RUN);
        chk("t3_branch_cnt", {32'd0, branch_cnt}, 64'd2);
        chk("t3_taken_cnt", {32'd0, taken_cnt}, 64'd1);
        chk("t3_redirect_pc_hold", redirect_pc, 64'h1040);

        idex_memread = 1'b1;
        idex_rd      = 5'd5;
        ifid_rs2     = 5'd5;
        cyc();
        chk_ctl("t4_stall_ctl", C_STALL);
        clear_ex();
        cyc();
        chk_ctl("t4_after_stall_ctl", C_RUN);
        idex_memread = 1'b1;
        idex_rd      = 5'd0;
        ifid_rs2     = 5'd0;
        cyc();
        chk_ctl("t4_x0_no_stall_ctl", C_RUN);
        clear_ex();

        set_taken(64'h0000_0000_0000_2080);
        idex_memread = 1'b1;
        idex_rd      = 5'd7;
        ifid_rs1     = 5'd7;
        cyc();
        chk_ctl("t5_priority_ctl", C_REDIR);
        chk("t5_branch_cnt", {32'd0, branch_cnt}, 64'd3);
        clear_ex();
        mem_stall = 1'b1;
        #1;
        chk_ctl("t5_ms_comb_ctl", C_REDMS);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_ctl("t5_ms_hold_ctl", C_REDMS);
        end
        chk("t5_ms_redirect_pc", redirect_pc, 64'h2080);
        chk("t5_ms_taken_cnt", {32'd0, taken_cnt}, 64'd2);
        mem_stall = 1'b0;
        #1;
        chk_ctl("t5_release_ctl", C_REDIR);
        cyc();
        chk_ctl("t5_flush_ctl", C_FLUSH);
        cyc();
        chk_ctl("t5_run_ctl", C_RUN);

        set_taken(64'h3000);
        mem_stall = 1'b1;
        cyc();
        chk_ctl("t5_run_ms_ctl", 5'b0_0_0_0_0);
        chk("t5_run_ms_branch_cnt", {32'd0, branch_cnt}, 64'd3);
        chk("t5_run_ms_redirect_pc", redirect_pc, 64'h2080);
        mem_stall = 1'b0;

        set_taken(64'h0000_0000_0000_30C0);
        cyc();
        chk_ctl("t6_redirect_ctl", C_REDIR);
        chk("t6_branch_cnt", {32'd0, branch_cnt}, 64'd4);
        clear_ex();
        cyc();
        chk_ctl("t6_flush_ctl", C_FLUSH);
        #2;
        reset_n = 1'b0;
        #1;
        chk_ctl("t6_async_reset_ctl", C_RUN);
        chk("t6_async_reset_pc", redirect_pc, 64'd0);
        chk("t6_async_reset_bcnt", {32'd0, branch_cnt}, 64'd0);
        chk("t6_async_reset_tcnt", {32'd0, taken_cnt}, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk_ctl("t6_post_reset_ctl", C_RUN);

        set_taken(64'h4000);
        cyc();
        chk("s_redirect_sel", {63'd0, s_pc_sel}, 64'd1);
        chk("s_redirect_pc", s_redirect_pc, 64'h4000);
        clear_ex();
        cyc();
        chk("s_fc1_back_to_run", {61'd0, s_pc_sel, s_ifid_flush, s_idex_flush}, 64'd0);
        for (int i = 0; i < 19; i++) begin
            set_taken(64'h4000 + 64'(i));
            cyc();
            clear_ex();
            cyc();
            if (i == 13) begin
                chk("s_cnt_at_15", {60'd0, s_branch_cnt}, 64'hF);
            end
        end
        chk("s_branch_cnt_sat", {60'd0, s_branch_cnt}, 64'hF);
        chk("s_taken_cnt_sat", {60'd0, s_taken_cnt}, 64'hF);
        chk("s_run_write", {62'd0, s_pc_write, s_ifid_write}, 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
